// File: rtl/fnd_scan_counter.sv
// rtl/fnd_scan_counter.sv - FND scan counter: prescaled digit select, frame-latched nibble, on/off state (optional FND_LEADING_ZERO_BLANK_EN)
module fnd_scan_counter #(
  parameter int DIV_COUNT = 100000,
  parameter bit POWER_ON  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_value,
  input  logic        i_onOffBtn,
  output logic [2:0]  o_select,
  output logic [3:0]  o_digitValue,
  output logic        o_blank,
  output logic        o_on,
  output logic        o_frameStart
);

  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_COUNT - 1);

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } stateType;

  stateType      state, stateNext;
  logic [PW-1:0] prescaler, prescNext;
  logic [15:0]   latchValue, latchNext;
  logic [2:0]    selNext;
  logic [3:0]    digitNext;
  logic          frameNext;
  logic          blankNext;
  logic          btnDly;
  logic          btnEdge;
  logic          tick;

  function automatic logic [3:0] nibbleOf(input logic [15:0] v, input logic [1:0] idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Index of the most significant non-zero nibble; 0 when the value is 0,
  // which keeps digit 0 visible so a zero value still shows one "0".
  function automatic logic [1:0] topDigit(input logic [15:0] v);
    logic [1:0] top;
    top = 2'd0;
    for (int k = 1; k < 4; k++) begin
      if (v[k*4 +: 4] != 4'd0) top = 2'(k);
    end
    return top;
  endfunction
`endif

  assign o_on    = (state == RUN);
  assign btnEdge = i_onOffBtn & ~btnDly;
  assign tick    = (prescaler == PRESC_LAST);

  // Next-state and next-output decode: button edge outranks the scan tick.
  always_comb begin
    stateNext = state;
    prescNext = prescaler;
    selNext   = o_select;
    latchNext = latchValue;
    digitNext = o_digitValue;
    frameNext = 1'b0;
    case (state)
      OFF: begin
        prescNext = '0;
        selNext   = 3'd0;
        digitNext = 4'd0;
        if (btnEdge) begin
          stateNext = RUN;
          latchNext = i_value;
          digitNext = i_value[3:0];
          frameNext = 1'b1;
        end
      end
      RUN: begin
        if (btnEdge) begin
          stateNext = OFF;
          prescNext = '0;
          selNext   = 3'd0;
          digitNext = 4'd0;
        end else if (tick) begin
          prescNext = '0;
          selNext   = o_select + 3'd1;
          if (o_select == 3'd7) begin
            latchNext = i_value;
            digitNext = i_value[3:0];
            frameNext = 1'b1;
          end else begin
            digitNext = nibbleOf(latchValue, selNext[1:0]);
          end
        end else begin
          prescNext = prescaler + PW'(1);
        end
      end
      default: begin
        stateNext = OFF;
      end
    endcase
`ifdef FND_LEADING_ZERO_BLANK_EN
    blankNext = (stateNext == OFF) || (selNext[1:0] > topDigit(latchNext));
`else
    blankNext = (stateNext == OFF);
`endif
  end

  // State and output registers; blank is registered alongside select.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= stateType'(POWER_ON);
      prescaler    <= '0;
      o_select     <= 3'd0;
      latchValue   <= 16'd0;
      o_digitValue <= 4'd0;
      btnDly       <= 1'b0;
      o_frameStart <= 1'b0;
      o_blank      <= ~POWER_ON;
    end else begin
      state        <= stateNext;
      prescaler    <= prescNext;
      o_select     <= selNext;
      latchValue   <= latchNext;
      o_digitValue <= digitNext;
      btnDly       <= i_onOffBtn;
      o_frameStart <= frameNext;
      o_blank      <= blankNext;
    end
  end

endmodule

// File: tb/tb_fnd_scan_counter.sv
// tb/tb_fnd_scan_counter.sv - scoreboard bench for fnd_scan_counter, POWER_ON=1 and POWER_ON=0 instances
module tb_fnd_scan_counter;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [15:0] value;
  logic        btn;
  logic [2:0]  sel0, sel1;
  logic [3:0]  dig0, dig1;
  logic        blank0, blank1, on0, on1, fs0, fs1;

  fnd_scan_counter #(.DIV_COUNT(DIV), .POWER_ON(1'b1)) dutOn (
    .i_clk(clk), .i_reset(resetn), .i_value(value), .i_onOffBtn(btn),
    .o_select(sel0), .o_digitValue(dig0), .o_blank(blank0), .o_on(on0), .o_frameStart(fs0)
  );

  fnd_scan_counter #(.DIV_COUNT(DIV), .POWER_ON(1'b0)) dutOff (
    .i_clk(clk), .i_reset(resetn), .i_value(value), .i_onOffBtn(btn),
    .o_select(sel1), .o_digitValue(dig1), .o_blank(blank1), .o_on(on1), .o_frameStart(fs1)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] dig;
    logic       blank;
    logic       on;
    logic       fs;
  } obsT;

  typedef struct packed {
    obsT a;
    obsT b;
  } expT;

  expT sbq[$];
  int  total = 0;
  int  bad   = 0;

  // Reference model: time since the frame started, the latched value and power state.
  bit          mOn[2];
  int          mPhase[2];
  logic [15:0] mLatch[2];
  bit          mFs[2];
  bit          mBtnPrev = 1'b0;

  function automatic int topNz(input logic [15:0] v);
    int t = 0;
    for (int k = 0; k < 4; k++) if (((v >> (4 * k)) & 16'hF) != 0) t = k;
    return t;
  endfunction

  function automatic obsT predict(input int i);
    obsT o;
    int  s;
    if (!mOn[i]) begin
      o = '{sel: 3'd0, dig: 4'd0, blank: 1'b1, on: 1'b0, fs: 1'b0};
    end else begin
      s       = mPhase[i] / DIV;
      o.sel   = 3'(s);
      o.dig   = 4'((mLatch[i] >> (4 * (s % 4))) & 16'hF);
`ifdef FND_LEADING_ZERO_BLANK_EN
      o.blank = ((s % 4) > topNz(mLatch[i]));
`else
      o.blank = 1'b0;
`endif
      o.on    = 1'b1;
      o.fs    = mFs[i];
    end
    return o;
  endfunction

  task automatic modelStep(input bit r, input logic [15:0] v, input bit b);
    bit edgeSeen;
    edgeSeen = b & ~mBtnPrev;
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        mOn[i]    = (i == 0);
        mPhase[i] = 0;
        mLatch[i] = 16'd0;
        mFs[i]    = 1'b0;
      end else begin
        mFs[i] = 1'b0;
        if (edgeSeen) begin
          mPhase[i] = 0;
          if (mOn[i]) begin
            mOn[i] = 1'b0;
          end else begin
            mOn[i]    = 1'b1;
            mLatch[i] = v;
            mFs[i]    = 1'b1;
          end
        end else if (mOn[i]) begin
          mPhase[i]++;
          if (mPhase[i] == FRAME) begin
            mPhase[i] = 0;
            mLatch[i] = v;
            mFs[i]    = 1'b1;
          end
        end
      end
    end
    mBtnPrev = r ? b : 1'b0;
  endtask

  task automatic step(input bit r, input logic [15:0] v, input bit b);
    expT e;
    @(negedge clk);
    resetn = r;
    value  = v;
    btn    = b;
    modelStep(r, v, b);
    e.a = predict(0);
    e.b = predict(1);
    sbq.push_back(e);
    @(posedge clk);
  endtask

  task automatic runUntilPhase(input int p, input logic [15:0] v);
    int n = 0;
    while (!(mOn[0] && mPhase[0] == p) && n < 4 * FRAME) begin
      step(1'b1, v, 1'b0);
      n++;
    end
    if (n >= 4 * FRAME) begin
      total++;
      bad++;
      $display("FAIL wait_phase: phase %0d not reached, got %0d", p, mPhase[0]);
    end
  endtask

  task automatic cmp(input string name, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t: got %0h want %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic checkObs(input int inst, input obsT e);
    obsT a;
    if (inst == 0) a = '{sel: sel0, dig: dig0, blank: blank0, on: on0, fs: fs0};
    else           a = '{sel: sel1, dig: dig1, blank: blank1, on: on1, fs: fs1};
    cmp("select", inst, int'(a.sel), int'(e.sel));
    cmp("digit",  inst, int'(a.dig), int'(e.dig));
    cmp("blank",  inst, int'(a.blank), int'(e.blank));
    cmp("on",     inst, int'(a.on), int'(e.on));
    cmp("frame",  inst, int'(a.fs), int'(e.fs));
  endtask

  // Monitor: every clock presents a new output word; compare it with the queued prediction.
  always @(posedge clk) begin
    expT e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkObs(0, e.a);
      checkObs(1, e.b);
    end
  end

  initial begin
    logic [15:0] v;
    logic [15:0] masks [6];
    bit          b;
    bit          r;
    masks  = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000, 16'h0F0F};
    resetn = 1'b0;
    value  = 16'd0;
    btn    = 1'b0;

    repeat (3) step(1'b0, 16'h1234, 1'b0);
    repeat (2 * FRAME + 2) step(1'b1, 16'h1234, 1'b0);

    runUntilPhase(2 * DIV, 16'h1234);
    repeat (FRAME + 4) step(1'b1, 16'hABCD, 1'b0);

    repeat (20) step(1'b1, 16'hABCD, 1'b1);
    repeat (6) step(1'b1, 16'hABCD, 1'b0);
    repeat (3) step(1'b1, 16'h5678, 1'b1);
    repeat (FRAME + 3) step(1'b1, 16'h5678, 1'b0);

    runUntilPhase(4 * DIV - 1, 16'h5678);
    step(1'b1, 16'h5678, 1'b1);
    repeat (5) step(1'b1, 16'h5678, 1'b0);
    step(1'b1, 16'h9ABC, 1'b1);
    repeat (FRAME) step(1'b1, 16'h9ABC, 1'b0);

    runUntilPhase(5 * DIV, 16'h9ABC);
    step(1'b0, 16'h9ABC, 1'b0);
    repeat (FRAME + 2) step(1'b1, 16'h0050, 1'b0);
    repeat (2 * FRAME) step(1'b1, 16'h0050, 1'b0);
    repeat (2 * FRAME) step(1'b1, 16'h0000, 1'b0);

    v = 16'h0123;
    b = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      r = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 9) == 0) v = 16'($urandom) & masks[$urandom_range(0, 5)];
      if ($urandom_range(0, 39) == 0) b = ~b;
      step(r, v, b);
    end

    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_scan_counter.md
Name: fnd_scan_counter

Overview:
- Upstream stage of the FND digit-position decoder; produces its 3-bit digit select and the matching 4-bit BCD/hex nibble for the segment decoder.
- Divides the system clock into a scan tick and cycles select 0..7. Select values 4..7 alias digits 0..3, so each digit is refreshed twice per frame.
- Latches the 16-bit display value once per frame so a digit cannot change mid-frame.
- Owns the display on/off state, toggled by a rising edge on a button input.

Parameters:
- DIV_COUNT, 100000, clocks per scan tick; 1 kHz at 100 MHz; legal range 2..2^24.
- POWER_ON, 1, state after reset: 1 = RUN, 0 = OFF.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-low reset.
- i_value  input  16  display value; nibble k drives digit k; digit 0 is the rightmost.
- i_onOffBtn  input  1  debounced, clock-synchronous button level; each rising edge toggles on/off.
- o_select  output  3  digit select to the position decoder.
- o_digitValue  output  4  nibble for the currently selected digit.
- o_blank  output  1  1 = segment decoder drives all segments off.
- o_on  output  1  1 = RUN state.
- o_frameStart  output  1  one-cycle pulse when i_value is latched.

Behaviour:
- Reset (i_reset==0 at a clock edge): prescaler=0, o_select=0, latch=0, o_digitValue=0, btn_d=0, o_frameStart=0, o_on=POWER_ON, o_blank=~POWER_ON.
- Prescaler: counter 0..DIV_COUNT-1, width $clog2(DIV_COUNT). tick=1 for one cycle when the count equals DIV_COUNT-1; the count then wraps to 0.
- Button edge: btn_d registers i_onOffBtn each cycle. edge = i_onOffBtn & ~btn_d.
- FSM has two states, OFF and RUN.
  - OFF: prescaler held at 0; o_select=0; o_digitValue=0; o_blank=1; o_on=0. On edge -> RUN. In the same edge the next-cycle values are loaded: prescaler=0, o_select=0, latch=i_value, o_digitValue=i_value[3:0], o_frameStart=1.
  - RUN: prescaler counts. On tick: o_select = o_select+1 mod 8, and o_digitValue = latch nibble (new o_select[1:0]) in the same edge, so select and nibble stay aligned with zero skew.
  - RUN, tick while o_select==7 (wrap to 0): latch=i_value, o_digitValue=i_value[3:0], o_frameStart=1 for one cycle.
  - RUN, on edge -> OFF: next-cycle outputs are the OFF values; o_blank=1.
- Priority: reset > edge > tick. If edge and tick coincide, the state change wins and the tick is discarded.
- A held button produces exactly one toggle. Release produces nothing.
- o_frameStart is 0 in every cycle not listed above.
- Frame period in RUN = 8*DIV_COUNT clocks. Changes to i_value between latches are invisible on the outputs.
- Reset mid-frame: all registers return to reset values on that edge. The scan restarts from select 0 after reset deassertion.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined: in RUN, o_blank=1 while the digit o_select[1:0] is above the highest non-zero nibble of the latch. Digit 0 is never blanked. Latch 0x0000 shows a single "0". o_blank is registered with o_select.
- Undefined: o_blank = ~o_on only.

Test Plan:
- DIV_COUNT=4, POWER_ON=1, i_value=16'h1234, release reset -> o_select 0,1,..,7,0 stepping every 4 clocks; o_digitValue 4,3,2,1,4,3,2,1.
- Change i_value to 16'hABCD at select 2 -> outputs unchanged until select wraps 7->0. o_frameStart pulses once; o_digitValue=D at select 0.
- Button held high 20 cycles while RUN -> single transition to OFF: o_on=0, o_blank=1, o_select=0. Second press -> RUN with select 0 and a fresh latch.
- Button edge on the same cycle as tick with select==3 -> state goes OFF; select does not advance to 4.
- Assert i_reset=0 at select 5 for 1 cycle -> next cycle all outputs at reset values; POWER_ON=0 variant stays OFF.
- With FND_LEADING_ZERO_BLANK_EN, i_value=16'h0050 -> o_blank=1 at selects 2,3,6,7 and 0 at selects 0,1,4,5. i_value=0 -> only select 0 and 4 unblanked.
